// File: rtl/fifo_stream_drain_if.sv
// Valid/ready stream carrying drained FIFO words with a packet-boundary marker.
interface fifo_stream_drain_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/fifo_stream_drain.sv
// Drains a registered-output synchronous FIFO into a valid/ready stream, hiding the
// one-cycle read latency behind a small output buffer and marking packet boundaries.
module fifo_stream_drain #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BUF_DEPTH  = 3,
  parameter int unsigned PKT_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  fifo_stream_drain_if.master   m,
  output logic [15:0]           beat_cnt,
  output logic                  err_underflow
);

  localparam int unsigned IdxW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned OccW = $clog2(BUF_DEPTH + 1);

  localparam int unsigned     IdxLastInt = BUF_DEPTH - 1;
  localparam int unsigned     PktLastInt = PKT_LEN - 1;
  localparam logic [IdxW-1:0] IdxLast    = IdxLastInt[IdxW-1:0];
  localparam logic [15:0]     PktLast    = PktLastInt[15:0];
  localparam logic [OccW:0]   DepthLvl   = BUF_DEPTH[OccW:0];

  logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
  logic [IdxW-1:0]       wr_idx_q, wr_idx_d;
  logic [IdxW-1:0]       rd_idx_q, rd_idx_d;
  logic [OccW-1:0]       occ_q, occ_d;
  logic                  inflight_q;
  logic [15:0]           pkt_idx_q, pkt_idx_d;
  logic [15:0]           beat_cnt_q, beat_cnt_d;
  logic                  err_q, err_d;

  logic [OccW:0] level;
  logic          valid;
  logic          pop;
  logic          cap;

  // Reads are throttled on buffered plus in-flight words, so m_ready never reaches fifo_rd_en.
  always_comb begin
    level      = {1'b0, occ_q} + {{OccW{1'b0}}, inflight_q};
    fifo_rd_en = !rst && en && !fifo_empty && (level < DepthLvl);
    valid      = !rst && (occ_q != '0);
    pop        = valid && m.m_ready;
    cap        = inflight_q;
  end

  always_comb begin
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    occ_d      = occ_q;
    pkt_idx_d  = pkt_idx_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q | fifo_underflow;

    if (cap) begin
      wr_idx_d = (wr_idx_q == IdxLast) ? '0 : wr_idx_q + 1'b1;
    end

    if (pop) begin
      rd_idx_d   = (rd_idx_q == IdxLast) ? '0 : rd_idx_q + 1'b1;
      pkt_idx_d  = (pkt_idx_q == PktLast) ? '0 : pkt_idx_q + 16'd1;
      beat_cnt_d = beat_cnt_q + 16'd1;
    end

    if (cap && !pop) begin
      occ_d = occ_q + 1'b1;
    end else if (!cap && pop) begin
      occ_d = occ_q - 1'b1;
    end
  end

  // Clearing inflight_q on reset discards the word the FIFO returns right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      pkt_idx_q  <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      occ_q      <= occ_d;
      inflight_q <= fifo_rd_en;
      pkt_idx_q  <= pkt_idx_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && cap) begin
      buf_q[wr_idx_q] <= fifo_data_out;
    end
  end

  assign m.m_valid     = valid;
  assign m.m_data      = valid ? buf_q[rd_idx_q] : '0;
  assign m.m_last      = valid && (pkt_idx_q == PktLast);
  assign beat_cnt      = beat_cnt_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: behavioural FIFO source plus an in-order stream scoreboard.
module tb_fifo_stream_drain;

  localparam int unsigned DW = 16;
  localparam int unsigned BD = 3;
  localparam int unsigned PL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [DW-1:0] fifo_data_out = '0;
  logic          fifo_empty;
  logic          fifo_underflow = 1'b0;
  logic          fifo_rd_en;
  logic [15:0]   beat_cnt;
  logic          err_underflow;

  fifo_stream_drain_if #(.DATA_WIDTH(DW)) s_if ();

  fifo_stream_drain #(
    .DATA_WIDTH(DW),
    .BUF_DEPTH (BD),
    .PKT_LEN   (PL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .fifo_data_out (fifo_data_out),
    .fifo_empty    (fifo_empty),
    .fifo_underflow(fifo_underflow),
    .fifo_rd_en    (fifo_rd_en),
    .m             (s_if),
    .beat_cnt      (beat_cnt),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  // Source FIFO model: every word ever loaded, in order; registered read data.
  logic [DW-1:0] src [0:2047];
  logic [10:0]   src_cnt = '0;
  logic [10:0]   src_rd  = '0;

  assign fifo_empty = (src_rd == src_cnt);

  always @(posedge clk) begin
    fifo_underflow <= fifo_rd_en && fifo_empty;
    if (fifo_rd_en && !fifo_empty) begin
      fifo_data_out <= src[src_rd];
      src_rd        <= src_rd + 11'd1;
    end
  end

  // Scoreboard state: next expected source word, beats into packet, accepted beats.
  int          checks = 0;
  int          errors = 0;
  logic [10:0] out_idx = '0;
  int unsigned pkt_pos = 0;
  logic [15:0] total   = '0;

  // Per-cycle observations.
  int unsigned   rd_cnt = 0;
  bit            rd_when_empty = 1'b0;
  logic          s_valid, s_last, s_hs, s_rd;
  logic [DW-1:0] s_data;
  logic [DW-1:0] got_d [$];
  logic          got_l [$];

  task automatic load(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      src[src_cnt] = rnd ? 16'($urandom) : 16'(i + 1);
      src_cnt      = src_cnt + 11'd1;
    end
  endtask

  task automatic set_word(input logic [DW-1:0] w);
    src[src_cnt] = w;
    src_cnt      = src_cnt + 11'd1;
  endtask

  // Sample mid-cycle, then move just past the next rising edge for new stimulus.
  task automatic tick();
    @(negedge clk);
    s_valid = s_if.m_valid;
    s_data  = s_if.m_data;
    s_last  = s_if.m_last;
    s_rd    = fifo_rd_en;
    s_hs    = s_valid && s_if.m_ready;
    if (s_rd) rd_cnt++;
    if (s_rd && fifo_empty) rd_when_empty = 1'b1;
    if (s_hs) begin
      got_d.push_back(s_data);
      got_l.push_back(s_last);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_stream();
    int hs_at [$];
    rst = 1'b1;
    en  = 1'b1;
    s_if.m_ready = 1'b1;
    load(8, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (s_valid !== 1'b0 || s_last !== 1'b0 || s_data !== '0 || s_rd !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: valid=%b last=%b data=%h rd_en=%b, expected all 0",
                 s_valid, s_last, s_data, s_rd);
      end
    end
    rst = 1'b0;
    checks++;
    if (beat_cnt !== 16'd0 || err_underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: beat_cnt=%0d err=%b, expected 0 0", beat_cnt, err_underflow);
    end
    for (int i = 0; i < 11; i++) begin
      tick();
      if (i == 0) begin
        checks++;
        if (s_rd !== 1'b1) begin
          errors++;
          $display("FAIL first_read: rd_en=%b, expected 1", s_rd);
        end
      end
      if (s_hs) hs_at.push_back(i);
    end
    checks++;
    if (hs_at.size() != 8) begin
      errors++;
      $display("FAIL stream_count: got %0d beats, expected 8", hs_at.size());
    end
    foreach (hs_at[k]) begin
      checks++;
      if (hs_at[k] != k + 2) begin
        errors++;
        $display("FAIL stream_timing[%0d]: cycle %0d, expected %0d", k, hs_at[k], k + 2);
      end
    end
    foreach (got_d[k]) begin
      checks++;
      if (got_d[k] !== src[out_idx] || got_l[k] !== ((pkt_pos + 1) % PL == 0)) begin
        errors++;
        $display("FAIL stream_beat[%0d]: data=%h last=%b, expected data=%h last=%b", k,
                 got_d[k], got_l[k], src[out_idx], ((pkt_pos + 1) % PL == 0));
      end
      out_idx = out_idx + 11'd1;
      pkt_pos = (pkt_pos + 1) % PL;
      total   = total + 16'd1;
    end
    got_d.delete();
    got_l.delete();
    checks++;
    if (beat_cnt !== total || err_underflow !== 1'b0) begin
      errors++;
      $display("FAIL stream_end: beat_cnt=%0d err=%b, expected %0d 0", beat_cnt, err_underflow,
               total);
    end
  endtask

  task automatic test_backpressure();
    int budget;
    s_if.m_ready = 1'b0;
    rd_cnt = 0;
    load(8, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i >= 2) begin
        checks++;
        if (s_valid !== 1'b1 || s_data !== 16'h0001 || s_last !== 1'b0) begin
          errors++;
          $display("FAIL bp_hold: valid=%b data=%h last=%b, expected 1 0001 0",
                   s_valid, s_data, s_last);
        end
      end
    end
    checks++;
    if (rd_cnt != 3) begin
      errors++;
      $display("FAIL bp_reads: %0d reads issued, expected 3", rd_cnt);
    end
    s_if.m_ready = 1'b1;
    budget = 40;
    while (got_d.size() < 8 && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if (got_d.size() != 8) begin
      errors++;
      $display("FAIL bp_count: got %0d beats, expected 8", got_d.size());
    end
    foreach (got_d[k]) begin
      checks++;
      if (got_d[k] !== src[out_idx] || got_l[k] !== ((pkt_pos + 1) % PL == 0)) begin
        errors++;
        $display("FAIL bp_beat[%0d]: data=%h last=%b, expected data=%h last=%b", k,
                 got_d[k], got_l[k], src[out_idx], ((pkt_pos + 1) % PL == 0));
      end
      out_idx = out_idx + 11'd1;
      pkt_pos = (pkt_pos + 1) % PL;
      total   = total + 16'd1;
    end
    got_d.delete();
    got_l.delete();
  endtask

  task automatic test_single_word();
    rd_cnt = 0;
    rd_when_empty = 1'b0;
    s_if.m_ready = 1'b1;
    set_word(16'hBEEF);
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (rd_cnt != 1 || rd_when_empty !== 1'b0 || err_underflow !== 1'b0) begin
      errors++;
      $display("FAIL single_reads: reads=%0d rd_on_empty=%b err=%b, expected 1 0 0",
               rd_cnt, rd_when_empty, err_underflow);
    end
    checks++;
    if (got_d.size() != 1 || got_d[0] !== 16'hBEEF) begin
      errors++;
      $display("FAIL single_beat: beats=%0d first=%h, expected 1 beef", got_d.size(),
               (got_d.size() > 0) ? got_d[0] : 16'h0);
    end
    foreach (got_d[k]) begin
      out_idx = out_idx + 11'd1;
      pkt_pos = (pkt_pos + 1) % PL;
      total   = total + 16'd1;
    end
    got_d.delete();
    got_l.delete();
  endtask

  task automatic test_random_ready();
    int budget;
    logic          p_stall;
    logic [DW-1:0] p_data;
    logic          p_last;
    rd_when_empty = 1'b0;
    p_stall = 1'b0;
    p_data  = '0;
    p_last  = 1'b0;
    load(1000, 1'b1);
    budget = 6000;
    while (got_d.size() < 1000 && budget > 0) begin
      s_if.m_ready = 1'($urandom_range(0, 1));
      tick();
      if (p_stall) begin
        checks++;
        if (s_valid !== 1'b1 || s_data !== p_data || s_last !== p_last) begin
          errors++;
          $display("FAIL rnd_stable: valid=%b data=%h last=%b, expected 1 %h %b",
                   s_valid, s_data, s_last, p_data, p_last);
        end
      end
      p_stall = s_valid && !s_hs;
      p_data  = s_data;
      p_last  = s_last;
      budget--;
    end
    checks++;
    if (got_d.size() != 1000) begin
      errors++;
      $display("FAIL rnd_count: got %0d beats, expected 1000", got_d.size());
    end
    foreach (got_d[k]) begin
      checks++;
      if (got_d[k] !== src[out_idx] || got_l[k] !== ((pkt_pos + 1) % PL == 0)) begin
        errors++;
        $display("FAIL rnd_beat[%0d]: data=%h last=%b, expected data=%h last=%b", k,
                 got_d[k], got_l[k], src[out_idx], ((pkt_pos + 1) % PL == 0));
      end
      out_idx = out_idx + 11'd1;
      pkt_pos = (pkt_pos + 1) % PL;
      total   = total + 16'd1;
    end
    got_d.delete();
    got_l.delete();
    s_if.m_ready = 1'b1;
    tick();
    checks++;
    if (beat_cnt !== total || err_underflow !== 1'b0 || rd_when_empty !== 1'b0) begin
      errors++;
      $display("FAIL rnd_end: beat_cnt=%0d err=%b rd_on_empty=%b, expected %0d 0 0",
               beat_cnt, err_underflow, rd_when_empty, total);
    end
  endtask

  task automatic test_mid_reset();
    int budget;
    s_if.m_ready = 1'b0;
    load(10, 1'b1);
    // Three cycles of reads leave two words buffered and one in flight.
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (s_valid !== 1'b0 || s_data !== '0 || s_last !== 1'b0 || s_rd !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_outputs: valid=%b data=%h last=%b rd_en=%b, expected all 0",
               s_valid, s_data, s_last, s_rd);
    end
    rst = 1'b0;
    s_if.m_ready = 1'b1;
    out_idx = src_rd;
    pkt_pos = 0;
    total   = '0;
    tick();
    checks++;
    if (s_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_valid: valid=%b, expected 0", s_valid);
    end
    budget = 40;
    while (got_d.size() < 7 && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if (got_d.size() != 7) begin
      errors++;
      $display("FAIL mid_rst_count: got %0d beats, expected 7", got_d.size());
    end
    foreach (got_d[k]) begin
      checks++;
      if (got_d[k] !== src[out_idx] || got_l[k] !== ((pkt_pos + 1) % PL == 0)) begin
        errors++;
        $display("FAIL mid_rst_beat[%0d]: data=%h last=%b, expected data=%h last=%b", k,
                 got_d[k], got_l[k], src[out_idx], ((pkt_pos + 1) % PL == 0));
      end
      out_idx = out_idx + 11'd1;
      pkt_pos = (pkt_pos + 1) % PL;
      total   = total + 16'd1;
    end
    got_d.delete();
    got_l.delete();
    checks++;
    if (beat_cnt !== total) begin
      errors++;
      $display("FAIL mid_rst_beat_cnt: beat_cnt=%0d, expected %0d", beat_cnt, total);
    end
  endtask

  task automatic test_en_gating();
    int budget;
    s_if.m_ready = 1'b0;
    load(10, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    en = 1'b0;
    s_if.m_ready = 1'b1;
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (got_d.size() != 3 || rd_cnt != 0 || s_valid !== 1'b0) begin
      errors++;
      $display("FAIL en_off: beats=%0d reads=%0d valid=%b, expected 3 0 0",
               got_d.size(), rd_cnt, s_valid);
    end
    en = 1'b1;
    budget = 40;
    while (got_d.size() < 10 && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if (got_d.size() != 10 || rd_cnt != 7) begin
      errors++;
      $display("FAIL en_resume: beats=%0d reads=%0d, expected 10 7", got_d.size(), rd_cnt);
    end
    foreach (got_d[k]) begin
      checks++;
      if (got_d[k] !== src[out_idx] || got_l[k] !== ((pkt_pos + 1) % PL == 0)) begin
        errors++;
        $display("FAIL en_beat[%0d]: data=%h last=%b, expected data=%h last=%b", k,
                 got_d[k], got_l[k], src[out_idx], ((pkt_pos + 1) % PL == 0));
      end
      out_idx = out_idx + 11'd1;
      pkt_pos = (pkt_pos + 1) % PL;
      total   = total + 16'd1;
    end
    got_d.delete();
    got_l.delete();
    checks++;
    if (beat_cnt !== total || err_underflow !== 1'b0) begin
      errors++;
      $display("FAIL en_end: beat_cnt=%0d err=%b, expected %0d 0", beat_cnt, err_underflow,
               total);
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    s_if.m_ready = 1'b0;
    test_reset_stream();
    test_backpressure();
    test_single_word();
    test_random_ready();
    test_mid_reset();
    test_en_gating();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
